apb_completer: RTL

APB4 completer (peripheral) placed directly downstream of the APB bridge: it answers the bridge's SETUP/ACCESS transfers from a bank of 32-bit registers. It inserts programmable wait states, enforces per-register PPROT permissions, and flags protocol violations and bad addresses on PSLVERR. It is the target the bridge's read, invalid-read and protection sequences exercise.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_regfile.sv | 42 ++++
 rtl/apb_completer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB4 completer and the bridge that drives it.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } completer_state_e;

  localparam int BYTE_LANES = 4;

  // PPROT bits a register demands: the low three bits of its word index.
  function automatic logic [2:0] req_pprot(input logic [2:0] idx);
    return idx;
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// Word register bank: byte-strobed synchronous write, combinational read.
module apb_regfile #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [LANES-1:0]      wstrb,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] rd_words [NUM_REGS];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
      logic [DATA_WIDTH-1:0] word_reg;

      always_ff @(posedge clk) begin
        if (srst) begin
          word_reg <= '0;
        end else if (we && (waddr == IDX_W'(gi))) begin
          for (int b = 0; b < LANES; b++) begin
            if (wstrb[b]) begin
              word_reg[b*8 +: 8] <= wdata[b*8 +: 8];
            end
          end
        end
      end

      assign rd_words[gi] = word_reg;
    end
  endgenerate

  assign rdata = rd_words[raddr];

endmodule

// File: rtl/apb_completer.sv
// APB4 completer: wait-state FSM, address/permission checks and response
// registers in front of an apb_regfile.
module apb_completer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [2:0]            pprot,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [BYTE_LANES-1:0] pstrb,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] prdata
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int IW    = ADDR_WIDTH - 2;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  completer_state_e      state_reg;
  logic [3:0]            cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  write_reg;
  logic [2:0]            prot_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [BYTE_LANES-1:0] strb_reg;
  logic                  pready_reg;
  logic                  pslverr_reg;
  logic [DATA_WIDTH-1:0] prdata_reg;

  logic [IW-1:0]         idx_full;
  logic [IDX_W-1:0]      rf_idx;
  logic [2:0]            req;
  logic                  align_err;
  logic                  range_err;
  logic                  prot_err;
  logic                  eval_err;
  logic                  setup_seen;
  logic                  access_ok;
  logic                  last_wait;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rf_rdata;

  assign idx_full   = addr_reg[ADDR_WIDTH-1:2];
  assign rf_idx     = idx_full[IDX_W-1:0];
  assign req        = req_pprot(idx_full[2:0]);
  assign align_err  = |addr_reg[1:0];
  assign range_err  = idx_full >= IW'(NUM_REGS);
  assign prot_err   = (prot_reg & req) != req;
  assign eval_err   = align_err | range_err | prot_err;
  assign setup_seen = psel & ~penable;
  assign access_ok  = psel & penable;
  assign last_wait  = cnt_reg == LAST_CNT;
  // Write lands on the same edge that raises pready.
  assign commit     = (state_reg == ACCESS) && access_ok && last_wait &&
                      !eval_err && write_reg;

  apb_regfile #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .LANES     (BYTE_LANES),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .clk  (pclk),
    .srst (preset),
    .we   (commit),
    .waddr(rf_idx),
    .wdata(wdata_reg),
    .wstrb(strb_reg),
    .raddr(rf_idx),
    .rdata(rf_rdata)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      prot_reg    <= '0;
      wdata_reg   <= '0;
      strb_reg    <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access_ok) begin
            state_reg   <= RESP;
            pready_reg  <= 1'b1;
            pslverr_reg <= 1'b1;
            prdata_reg  <= '0;
          end else if (setup_seen) begin
            state_reg <= ACCESS;
            cnt_reg   <= '0;
            addr_reg  <= paddr;
            write_reg <= pwrite;
            prot_reg  <= pprot;
            wdata_reg <= pwdata;
            strb_reg  <= pstrb;
          end
        end
        ACCESS: begin
          if (!access_ok) begin
            state_reg   <= RESP;
            pready_reg  <= 1'b1;
            pslverr_reg <= 1'b1;
            prdata_reg  <= '0;
          end else if (last_wait) begin
            state_reg   <= RESP;
            pready_reg  <= 1'b1;
            pslverr_reg <= eval_err;
            prdata_reg  <= (eval_err || write_reg) ? '0 : rf_rdata;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        RESP: begin
          pready_reg  <= 1'b0;
          pslverr_reg <= 1'b0;
          prdata_reg  <= '0;
          if (setup_seen) begin
            state_reg <= ACCESS;
            cnt_reg   <= '0;
            addr_reg  <= paddr;
            write_reg <= pwrite;
            prot_reg  <= pprot;
            wdata_reg <= pwdata;
            strb_reg  <= pstrb;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg   <= IDLE;
          pready_reg  <= 1'b0;
          pslverr_reg <= 1'b0;
          prdata_reg  <= '0;
        end
      endcase
    end
  end

  assign pready  = pready_reg;
  assign pslverr = pslverr_reg;
  assign prdata  = prdata_reg;

endmodule
